// File: rtl/id_stage.sv
// id_stage: IF/ID latch, decode, 16-entry register file and ID/EX register with load-use/halt interlock
// Ports: clk/rst (async active-low); instr_in/pc_in/valid_in from fetch; stall/flush pipeline control;
//        wb_en/wb_addr/wb_data writeback port; pc_en fetch enable; valid_out/pc_out/opcode/rd/
//        rs1_data/rs2_data/imm/reg_we registered ID/EX bundle.
module id_stage #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 6,
    parameter int REG_ADDR         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ARQ-1:0]              instr_in,
    input  logic [MEMORY_ADDR_SIZE-1:0] pc_in,
    input  logic                        valid_in,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        wb_en,
    input  logic [REG_ADDR-1:0]         wb_addr,
    input  logic [ARQ-1:0]              wb_data,
    output logic                        pc_en,
    output logic                        valid_out,
    output logic [MEMORY_ADDR_SIZE-1:0] pc_out,
    output logic [3:0]                  opcode,
    output logic [REG_ADDR-1:0]         rd,
    output logic [ARQ-1:0]              rs1_data,
    output logic [ARQ-1:0]              rs2_data,
    output logic [ARQ-1:0]              imm,
    output logic                        reg_we
);
    logic [ARQ-1:0]              r_ifid_instr;
    logic [MEMORY_ADDR_SIZE-1:0] r_ifid_pc;
    logic                        r_ifid_valid;
    logic [ARQ-1:0]              r_regs [1<<REG_ADDR];
    logic [3:0]                  w_op;
    logic [3:0]                  w_dec_op;
    logic [REG_ADDR-1:0]         w_rd;
    logic [REG_ADDR-1:0]         w_rs1_idx;
    logic [REG_ADDR-1:0]         w_rs2_idx;
    logic [ARQ-1:0]              w_rs1_val;
    logic [ARQ-1:0]              w_rs2_val;
    logic                        w_we;
    logic                        w_uses;
    logic                        w_wb_ok;
    logic                        w_hazard;
    logic                        w_halt;
    logic                        w_hold;

    assign w_op      = r_ifid_instr[15:12];
    // undefined opcodes collapse to NOP so nothing downstream acts on them
    assign w_dec_op  = (w_op <= 4'h8 || w_op == 4'hF) ? w_op : 4'h0;
    assign w_rd      = r_ifid_instr[8 +: REG_ADDR];
    assign w_rs1_idx = r_ifid_instr[4 +: REG_ADDR];
    assign w_rs2_idx = r_ifid_instr[0 +: REG_ADDR];
    assign w_we      = w_dec_op >= 4'h1 && w_dec_op <= 4'h6;
    assign w_uses    = (w_dec_op >= 4'h1 && w_dec_op <= 4'h4) || w_dec_op == 4'h7 || w_dec_op == 4'h8;
    assign w_wb_ok   = wb_en && wb_addr != '0;
    // write-through: a register being written this cycle is read as its new value
    assign w_rs1_val = (w_wb_ok && wb_addr == w_rs1_idx) ? wb_data : r_regs[w_rs1_idx];
    assign w_rs2_val = (w_wb_ok && wb_addr == w_rs2_idx) ? wb_data : r_regs[w_rs2_idx];
    assign w_hazard  = valid_out && opcode == 4'h6 && rd != '0 && r_ifid_valid && w_uses &&
                       (w_rs1_idx == rd || w_rs2_idx == rd);
    // a valid HALT parks in ID/EX; holding both registers keeps it there until flush/reset
    assign w_halt    = valid_out && opcode == 4'hF;
    assign w_hold    = stall || w_halt;
    assign pc_en     = ~(stall | w_hazard | w_halt) | flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < (1 << REG_ADDR); i++) r_regs[i] <= '0;
        end else if (w_wb_ok) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
            valid_out    <= 1'b0;
            pc_out       <= '0;
            opcode       <= '0;
            rd           <= '0;
            rs1_data     <= '0;
            rs2_data     <= '0;
            imm          <= '0;
            reg_we       <= 1'b0;
        end else if (flush) begin
            r_ifid_valid <= 1'b0;
            valid_out    <= 1'b0;
            reg_we       <= 1'b0;
        end else if (!w_hold) begin
            if (!w_hazard) begin
                r_ifid_instr <= instr_in;
                r_ifid_pc    <= pc_in;
                r_ifid_valid <= valid_in;
            end
            valid_out <= r_ifid_valid && !w_hazard;
            reg_we    <= r_ifid_valid && w_we && !w_hazard;
            pc_out    <= r_ifid_pc;
            opcode    <= w_dec_op;
            rd        <= w_rd;
            rs1_data  <= w_rs1_val;
            rs2_data  <= w_rs2_val;
            imm       <= {{(ARQ-8){1'b0}}, r_ifid_instr[7:0]};
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector bench for id_stage
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_in = '0;
    logic [5:0]  pc_in = '0;
    logic        valid_in = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        pc_en;
    logic        valid_out;
    logic [5:0]  pc_out;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] imm;
    logic        reg_we;

    typedef struct {
        logic [15:0] instr;
        logic [5:0]  pc;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] rs1;
        logic [15:0] rs2;
        logic [15:0] imm;
        logic        we;
    } vec_t;

    vec_t        tv [10];
    logic [15:0] rm [16];
    int          n_vec = 0;
    int          n_err = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_en(pc_en), .valid_out(valid_out), .pc_out(pc_out), .opcode(opcode), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .reg_we(reg_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [5:0] pc);
        instr_in = ins;
        pc_in    = pc;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
    endtask

    task automatic chk_zero_out(input string tag);
        chk({tag, " valid_out"}, 32'(valid_out), 0);
        chk({tag, " pc_out"}, 32'(pc_out), 0);
        chk({tag, " opcode"}, 32'(opcode), 0);
        chk({tag, " rd"}, 32'(rd), 0);
        chk({tag, " rs1"}, 32'(rs1_data), 0);
        chk({tag, " rs2"}, 32'(rs2_data), 0);
        chk({tag, " imm"}, 32'(imm), 0);
        chk({tag, " reg_we"}, 32'(reg_we), 0);
        chk({tag, " pc_en"}, 32'(pc_en), 1);
    endtask

    initial begin
        rm[0] = 16'h0000;
        rm[1] = 16'h5A5A;
        for (int i = 2; i < 16; i++) rm[i] = 16'(16'h0011 * (i - 1));
        tv[0] = '{16'h1123, 6'd5,  4'h1, 4'd1,  16'h0011, 16'h0022, 16'h0023, 1'b1};
        tv[1] = '{16'h2456, 6'd6,  4'h2, 4'd4,  16'h0044, 16'h0055, 16'h0056, 1'b1};
        tv[2] = '{16'h3A01, 6'd7,  4'h3, 4'd10, 16'h0000, 16'h5A5A, 16'h0001, 1'b1};
        tv[3] = '{16'h4F9E, 6'd8,  4'h4, 4'd15, 16'h0088, 16'h00DD, 16'h009E, 1'b1};
        tv[4] = '{16'h57FF, 6'd9,  4'h5, 4'd7,  16'h00EE, 16'h00EE, 16'h00FF, 1'b1};
        tv[5] = '{16'h6300, 6'd10, 4'h6, 4'd3,  16'h0000, 16'h0000, 16'h0000, 1'b1};
        tv[6] = '{16'h7812, 6'd11, 4'h7, 4'd8,  16'h5A5A, 16'h0011, 16'h0012, 1'b0};
        tv[7] = '{16'h8CDE, 6'd12, 4'h8, 4'd12, 16'h00CC, 16'h00DD, 16'h00DE, 1'b0};
        tv[8] = '{16'h0000, 6'h3F, 4'h0, 4'd0,  16'h0000, 16'h0000, 16'h0000, 1'b0};
        tv[9] = '{16'h9123, 6'd14, 4'h0, 4'd1,  16'h0011, 16'h0022, 16'h0023, 1'b0};

        #3;
        chk_zero_out("por");
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post-reset pc_en", 32'(pc_en), 1);

        for (int i = 1; i < 16; i++) begin
            wb_en   = 1'b1;
            wb_addr = 4'(i);
            wb_data = rm[i];
            step();
        end
        wb_en = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(tv[i].instr, tv[i].pc);
            chk($sformatf("v%0d valid_out", i), 32'(valid_out), 1);
            chk($sformatf("v%0d pc_out", i), 32'(pc_out), 32'(tv[i].pc));
            chk($sformatf("v%0d opcode", i), 32'(opcode), 32'(tv[i].op));
            chk($sformatf("v%0d rd", i), 32'(rd), 32'(tv[i].rd));
            chk($sformatf("v%0d rs1", i), 32'(rs1_data), 32'(tv[i].rs1));
            chk($sformatf("v%0d rs2", i), 32'(rs2_data), 32'(tv[i].rs2));
            chk($sformatf("v%0d imm", i), 32'(imm), 32'(tv[i].imm));
            chk($sformatf("v%0d reg_we", i), 32'(reg_we), 32'(tv[i].we));
            chk($sformatf("v%0d pc_en", i), 32'(pc_en), 1);
        end

        instr_in = 16'h2540; pc_in = 6'd16; valid_in = 1'b1;
        step();
        valid_in = 1'b0; wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'hBEEF;
        step();
        chk("bypass rs1", 32'(rs1_data), 32'hBEEF);
        chk("bypass rs2", 32'(rs2_data), 0);
        wb_addr = 4'd0; wb_data = 16'h1234;
        step();
        wb_en = 1'b0;
        issue(16'h1040, 6'd17);
        chk("r4 written", 32'(rs1_data), 32'hBEEF);
        chk("r0 stays 0", 32'(rs2_data), 0);

        instr_in = 16'h6300; pc_in = 6'd20; valid_in = 1'b1;
        step();
        instr_in = 16'h1130; pc_in = 6'd21;
        step();
        chk("lu load valid", 32'(valid_out), 1);
        chk("lu load op", 32'(opcode), 6);
        chk("lu pc_en", 32'(pc_en), 0);
        step();
        chk("lu bubble valid", 32'(valid_out), 0);
        chk("lu bubble we", 32'(reg_we), 0);
        chk("lu bubble pc", 32'(pc_out), 21);
        chk("lu pc_en back", 32'(pc_en), 1);
        valid_in = 1'b0;
        step();
        chk("lu add valid", 32'(valid_out), 1);
        chk("lu add op", 32'(opcode), 1);
        chk("lu add pc", 32'(pc_out), 21);
        chk("lu add rs1", 32'(rs1_data), 32'h0022);
        chk("lu add we", 32'(reg_we), 1);

        instr_in = 16'h6500; pc_in = 6'd30; valid_in = 1'b1;
        step();
        instr_in = 16'h5150; pc_in = 6'd31;
        step();
        chk("ldi no hazard", 32'(pc_en), 1);
        valid_in = 1'b0;
        step();
        chk("ldi issued", 32'(valid_out), 1);
        step();

        instr_in = 16'h1123; pc_in = 6'd40; valid_in = 1'b1;
        step();
        instr_in = 16'h2456; pc_in = 6'd41;
        step();
        chk("pre-stall pc", 32'(pc_out), 40);
        stall = 1'b1; instr_in = 16'h3A01; pc_in = 6'd42;
        #1;
        chk("stall pc_en", 32'(pc_en), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d pc", i), 32'(pc_out), 40);
            chk($sformatf("stall%0d valid", i), 32'(valid_out), 1);
            chk($sformatf("stall%0d pc_en", i), 32'(pc_en), 0);
        end
        flush = 1'b1;
        #1;
        chk("stall+flush pc_en", 32'(pc_en), 1);
        step();
        stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        chk("flush valid_out", 32'(valid_out), 0);
        chk("flush reg_we", 32'(reg_we), 0);
        chk("flush pc_en", 32'(pc_en), 1);
        step();
        chk("flushed ifid", 32'(valid_out), 0);

        issue(16'hF000, 6'd50);
        instr_in = 16'h1123; pc_in = 6'd51; valid_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("halt%0d pc_en", i), 32'(pc_en), 0);
            chk($sformatf("halt%0d op", i), 32'(opcode), 32'hF);
            step();
        end
        flush = 1'b1;
        #1;
        chk("halt flush pc_en", 32'(pc_en), 1);
        step();
        flush = 1'b0; valid_in = 1'b0;
        chk("unhalt pc_en", 32'(pc_en), 1);
        chk("unhalt valid", 32'(valid_out), 0);

        issue(16'h1123, 6'd5);
        chk("pre-rst valid", 32'(valid_out), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_zero_out("async rst");
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst release pc_en", 32'(pc_en), 1);
        for (int i = 1; i < 16; i++) begin
            issue({4'h1, 4'h0, 4'(i), 4'(i)}, 6'(i));
            chk($sformatf("r%0d cleared rs1", i), 32'(rs1_data), 0);
            chk($sformatf("r%0d cleared rs2", i), 32'(rs2_data), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
